// File: rtl/sa_pkg.sv
// Shared types and constants for the systolic-array result path.
// Holds the TX scheduler state encoding, grant codes and default header bytes.
package sa_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StHdr,
    StLoad,
    StWaitDone
  } tx_sched_state_t;

  localparam logic [1:0] GNT_COL = 2'b01;
  localparam logic [1:0] GNT_ROW = 2'b10;

  localparam logic [7:0] HDR_COL_DEFAULT = 8'hC0;
  localparam logic [7:0] HDR_ROW_DEFAULT = 8'hA0;

endpackage

// File: rtl/sa_tx_scheduler.sv
// Round-robin burst scheduler sharing one uart_tx between the column and row result streams.
// Each grant sends an optional source header, then up to PKT_BYTES payload bytes.
module sa_tx_scheduler
  import sa_pkg::*;
#(
  parameter int unsigned       W_DATA    = 8,
  parameter int unsigned       PKT_BYTES = 32,
  parameter bit                HDR_EN    = 1'b1,
  parameter logic [W_DATA-1:0] HDR_COL   = W_DATA'(HDR_COL_DEFAULT),
  parameter logic [W_DATA-1:0] HDR_ROW   = W_DATA'(HDR_ROW_DEFAULT)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_col_valid,
  input  logic [W_DATA-1:0] i_col_data,
  output logic              o_col_ready,
  input  logic              i_row_valid,
  input  logic [W_DATA-1:0] i_row_data,
  output logic              o_row_ready,
  output logic              o_tx_dv,
  output logic [W_DATA-1:0] o_tx_byte,
  input  logic              i_tx_done,
  output logic [1:0]        o_grant,
  output logic              o_busy
);

  localparam logic [7:0] PKT_LAST = 8'(PKT_BYTES);

  tx_sched_state_t   state_q;
  logic [7:0]        count_q;
  logic              last_row_q;
  logic [1:0]        grant_q;
  logic              busy_q;
  logic              tx_dv_q;
  logic [W_DATA-1:0] tx_byte_q;
  logic              col_ready_q;
  logic              row_ready_q;

  logic              sel_valid;
  logic [W_DATA-1:0] sel_data;

  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    if (grant_q == GNT_COL) begin
      sel_valid = i_col_valid;
      sel_data  = i_col_data;
    end else if (grant_q == GNT_ROW) begin
      sel_valid = i_row_valid;
      sel_data  = i_row_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= StIdle;
      count_q     <= '0;
      last_row_q  <= 1'b1;
      grant_q     <= '0;
      busy_q      <= 1'b0;
      tx_dv_q     <= 1'b0;
      tx_byte_q   <= '0;
      col_ready_q <= 1'b0;
      row_ready_q <= 1'b0;
    end else begin
      // Strobes are single-cycle; only LOAD/HDR re-assert them.
      tx_dv_q     <= 1'b0;
      col_ready_q <= 1'b0;
      row_ready_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_col_valid || i_row_valid) begin
            // Tie goes to whichever source did not own the previous burst.
            if (i_col_valid && (!i_row_valid || last_row_q)) begin
              grant_q <= GNT_COL;
            end else begin
              grant_q <= GNT_ROW;
            end
            count_q <= '0;
            busy_q  <= 1'b1;
            state_q <= HDR_EN ? StHdr : StLoad;
          end
        end
        StHdr: begin
          tx_dv_q   <= 1'b1;
          tx_byte_q <= (grant_q == GNT_COL) ? HDR_COL : HDR_ROW;
          state_q   <= StWaitDone;
        end
        StLoad: begin
          if (sel_valid) begin
            tx_dv_q     <= 1'b1;
            tx_byte_q   <= sel_data;
            col_ready_q <= (grant_q == GNT_COL);
            row_ready_q <= (grant_q == GNT_ROW);
            count_q     <= count_q + 8'd1;
            state_q     <= StWaitDone;
          end else begin
            last_row_q <= (grant_q == GNT_ROW);
            grant_q    <= '0;
            busy_q     <= 1'b0;
            state_q    <= StIdle;
          end
        end
        StWaitDone: begin
          if (i_tx_done) begin
            if (count_q == PKT_LAST) begin
              last_row_q <= (grant_q == GNT_ROW);
              grant_q    <= '0;
              busy_q     <= 1'b0;
              state_q    <= StIdle;
            end else begin
              state_q <= StLoad;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_col_ready = col_ready_q;
  assign o_row_ready = row_ready_q;
  assign o_tx_dv     = tx_dv_q;
  assign o_tx_byte   = tx_byte_q;
  assign o_grant     = grant_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_sa_tx_scheduler.sv
// Bench for sa_tx_scheduler: FIFO and uart_tx emulation around the DUT, with the expected
// byte stream derived from the arbitration rules over the queued FIFO contents.
module tb_sa_tx_scheduler;
  import sa_pkg::*;

  localparam int unsigned PKT = 2;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       col_valid, row_valid, col_ready, row_ready;
  logic [7:0] col_data, row_data, tx_byte;
  logic       tx_dv, tx_done, busy;
  logic [1:0] grant;

  logic       nh_valid, nh_ready, nh_row_ready, nh_dv, nh_done, nh_busy;
  logic [7:0] nh_data, nh_byte;
  logic [1:0] nh_grant;

  sa_tx_scheduler #(.W_DATA(8), .PKT_BYTES(PKT), .HDR_EN(1'b1)) u_dut (
    .i_clk(clk), .i_rst(rst),
    .i_col_valid(col_valid), .i_col_data(col_data), .o_col_ready(col_ready),
    .i_row_valid(row_valid), .i_row_data(row_data), .o_row_ready(row_ready),
    .o_tx_dv(tx_dv), .o_tx_byte(tx_byte), .i_tx_done(tx_done),
    .o_grant(grant), .o_busy(busy)
  );

  // Header-less instance with single-byte bursts.
  sa_tx_scheduler #(.W_DATA(8), .PKT_BYTES(1), .HDR_EN(1'b0)) u_dut_nh (
    .i_clk(clk), .i_rst(rst),
    .i_col_valid(nh_valid), .i_col_data(nh_data), .o_col_ready(nh_ready),
    .i_row_valid(1'b0), .i_row_data(8'h00), .o_row_ready(nh_row_ready),
    .o_tx_dv(nh_dv), .o_tx_byte(nh_byte), .i_tx_done(nh_done),
    .o_grant(nh_grant), .o_busy(nh_busy)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] col_q[$], row_q[$], exp_q[$], obs_q[$], nh_q[$];
  bit         model_last_col;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected stream: alternate on ties, otherwise serve whoever has data, bursts capped at PKT.
  function automatic void build_expected();
    int ci = 0;
    int ri = 0;
    bit pick_col;
    exp_q.delete();
    while (ci < col_q.size() || ri < row_q.size()) begin
      if (ci < col_q.size() && ri < row_q.size()) pick_col = !model_last_col;
      else pick_col = (ci < col_q.size());
      if (pick_col) begin
        exp_q.push_back(HDR_COL_DEFAULT);
        for (int k = 0; k < PKT && ci < col_q.size(); k++) exp_q.push_back(col_q[ci++]);
      end else begin
        exp_q.push_back(HDR_ROW_DEFAULT);
        for (int k = 0; k < PKT && ri < row_q.size(); k++) exp_q.push_back(row_q[ri++]);
      end
      model_last_col = pick_col;
    end
  endfunction

  task automatic drive_inputs();
    col_valid = (col_q.size() != 0);
    col_data  = col_valid ? col_q[0] : 8'h00;
    row_valid = (row_q.size() != 0);
    row_data  = row_valid ? row_q[0] : 8'h00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; tx_done = 1'b0; col_valid = 1'b0; row_valid = 1'b0; nh_valid = 1'b0;
    @(negedge clk);
    check("rst_tx_dv", tx_dv, 0);
    check("rst_tx_byte", tx_byte, 0);
    check("rst_col_ready", col_ready, 0);
    check("rst_row_ready", row_ready, 0);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    model_last_col = 1'b0;
  endtask

  task automatic run_burst(input string tag, input bit slow_first, input int abort_after,
                           input bit stray_done);
    int cyc = 0;
    int first_g = -1;
    int first_dv = -1;
    int pend = 0;
    int idle_run = 0;
    logic [7:0] held = 8'h00;
    build_expected();
    obs_q.delete();
    drive_inputs();
    tx_done = stray_done;
    forever begin
      @(negedge clk);
      cyc++;
      tx_done = 1'b0;
      if (grant != 2'b00 && first_g < 0) first_g = cyc;
      check({tag, "_grant_onehot0"}, 32'($onehot0(grant)), 1);
      if (tx_dv) begin
        if (first_dv < 0) first_dv = cyc;
        check({tag, "_dv_while_tx_busy"}, 32'(pend != 0), 0);
        obs_q.push_back(tx_byte);
        held = tx_byte;
        pend = (slow_first && obs_q.size() == 1) ? 5000 : int'($urandom_range(1, 6));
      end else begin
        if (obs_q.size() > 0) check({tag, "_tx_byte_hold"}, tx_byte, held);
        if (pend > 0) begin
          pend--;
          if (pend == 0) tx_done = 1'b1;
        end
      end
      if (col_ready) begin
        check({tag, "_col_pop"}, {grant == GNT_COL, tx_dv, col_q.size() != 0}, 3'b111);
        if (col_q.size() != 0) void'(col_q.pop_front());
      end
      if (row_ready) begin
        check({tag, "_row_pop"}, {grant == GNT_ROW, tx_dv, row_q.size() != 0}, 3'b111);
        if (row_q.size() != 0) void'(row_q.pop_front());
      end
      drive_inputs();
      if (abort_after > 0 && tx_dv && obs_q.size() == abort_after) break;
      if (obs_q.size() >= exp_q.size() && !busy && pend == 0) idle_run++;
      else idle_run = 0;
      if (idle_run >= 4) break;
      if (cyc > 20000) begin
        check({tag, "_timeout"}, 1, 0);
        break;
      end
    end
    if (abort_after == 0) begin
      check({tag, "_nbytes"}, obs_q.size(), exp_q.size());
      check({tag, "_fifos_drained"}, col_q.size() + row_q.size(), 0);
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), obs_q[i], exp_q[i]);
    if (exp_q.size() > 0) begin
      check({tag, "_grant_latency"}, first_g, 1);
      check({tag, "_dv_latency"}, first_dv, 2);
    end
  endtask

  task automatic nh_run(input string tag);
    logic [7:0] exp_b[$];
    logic [7:0] got_b[$];
    int first = -1;
    int pend = 0;
    exp_b = nh_q;
    nh_valid = (nh_q.size() != 0);
    nh_data  = nh_valid ? nh_q[0] : 8'h00;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      nh_done = 1'b0;
      if (nh_dv) begin
        if (first < 0) first = c;
        got_b.push_back(nh_byte);
        pend = 3;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) nh_done = 1'b1;
      end
      if (nh_ready) begin
        check({tag, "_ready_with_dv"}, {nh_dv, nh_q.size() != 0}, 2'b11);
        if (nh_q.size() != 0) void'(nh_q.pop_front());
      end
      nh_valid = (nh_q.size() != 0);
      nh_data  = nh_valid ? nh_q[0] : 8'h00;
    end
    check({tag, "_nbytes"}, got_b.size(), exp_b.size());
    for (int i = 0; i < got_b.size() && i < exp_b.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), got_b[i], exp_b[i]);
    check({tag, "_dv_latency"}, first, 2);
    check({tag, "_end_grant"}, nh_grant, 0);
  endtask

  initial begin
    rst = 1'b1; tx_done = 1'b0; col_valid = 1'b0; row_valid = 1'b0;
    col_data = 8'h00; row_data = 8'h00;
    nh_valid = 1'b0; nh_data = 8'h00; nh_done = 1'b0;
    model_last_col = 1'b0;
    repeat (2) @(negedge clk);

    // Single column burst with a slow first done
    do_reset();
    col_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_burst("col_slow", 1'b1, 0, 1'b0);

    // Contention: strict alternation, column first after reset
    do_reset();
    col_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    row_q = '{8'hF1, 8'hF2, 8'hF3, 8'hF4};
    run_burst("contend", 1'b0, 0, 1'b0);

    // Short row burst, later column request
    row_q = '{8'h5A};
    run_burst("short_row", 1'b0, 0, 1'b0);
    col_q = '{8'h77};
    run_burst("late_col", 1'b0, 0, 1'b0);

    // Reset while waiting on the second payload byte, then stray done in IDLE
    do_reset();
    col_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    row_q = '{8'hF1, 8'hF2, 8'hF3, 8'hF4};
    run_burst("pre_rst", 1'b0, 3, 1'b0);
    do_reset();
    run_burst("post_rst", 1'b0, 0, 1'b1);

    for (int t = 0; t < 14; t++) begin
      int nc;
      int nr;
      if (t % 3 == 0) do_reset();
      nc = int'($urandom_range(0, 7));
      nr = int'($urandom_range(0, 7));
      for (int i = 0; i < nc; i++) col_q.push_back(8'($urandom));
      for (int i = 0; i < nr; i++) row_q.push_back(8'($urandom));
      run_burst($sformatf("rand%0d", t), 1'b0, 0, 1'b0);
    end

    do_reset();
    check("nh_rst_busy", nh_busy, 0);
    nh_q = '{8'h7E};
    nh_run("nh_single");
    nh_q = '{8'h7E, 8'h81};
    nh_run("nh_pair");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sa_tx_scheduler.md
# sa_tx_scheduler

Shares one `uart_tx` between the two output-FIFO streams of the systolic-array result path: the column stream (32-bit south outputs, serialised) and the row stream (east outputs). It grants one requester at a time in round-robin bursts of up to `PKT_BYTES` bytes. Each burst is optionally prefixed with a source-ID header byte. It drives the transmitter's data-valid/byte inputs and paces itself on the transmitter's done pulse, so the top level needs a single serial output instead of two.

## Interface
- `W_DATA`, 8: byte width on all data ports.
- `PKT_BYTES`, 32: maximum payload bytes per burst before the grant rotates; legal range 1..255.
- `HDR_EN`, 1: 1 = send a header byte before each burst; 0 = no header.
- `HDR_COL`, 8'hC0: header byte for column bursts.
- `HDR_ROW`, 8'hA0: header byte for row bursts.

Ports:
- `i_clk`  in  1  system clock (100 MHz).
- `i_rst`  in  1  synchronous, active-high reset.
- `i_col_valid`  in  1  column FIFO non-empty; `i_col_data` is valid (show-ahead).
- `i_col_data`  in  W_DATA  column head byte; held stable until popped.
- `o_col_ready`  out  1  one-cycle pop strobe to the column FIFO.
- `i_row_valid`  in  1  row FIFO non-empty.
- `i_row_data`  in  W_DATA  row head byte.
- `o_row_ready`  out  1  one-cycle pop strobe to the row FIFO.
- `o_tx_dv`  out  1  one-cycle start pulse to `uart_tx`.
- `o_tx_byte`  out  W_DATA  byte to transmit; held until the next `o_tx_dv`.
- `i_tx_done`  in  1  one-cycle done pulse from `uart_tx`.
- `o_grant`  out  2  current owner: bit0 = column, bit1 = row; one-hot or zero.
- `o_busy`  out  1  high whenever state ≠ IDLE.

## Operation
- States: `IDLE`, `HDR`, `LOAD`, `WAIT_DONE`.
- **IDLE**, arbitration when any valid is high:
  - Only one valid high: grant it.
  - Both high: grant the source not granted last. The `last` flag resets to row, so column wins the first tie.
  - Clear the byte count; go to `HDR` if `HDR_EN`, else `LOAD`.
- **HDR**:
  - Register `o_tx_dv`=1 and `o_tx_byte` = `HDR_COL` or `HDR_ROW` per grant.
  - Go to `WAIT_DONE`. The header does not count toward `PKT_BYTES`.
- **LOAD**, granted source valid:
  - Register `o_tx_dv`=1 and `o_tx_byte` = its data.
  - Pulse its ready in the same cycle as `o_tx_dv`.
  - Increment the count; go to `WAIT_DONE`.
- **LOAD**, granted source not valid:
  - End the burst: update `last`, clear `o_grant`, go to `IDLE`. No byte is sent.
- **WAIT_DONE**:
  - Hold until `i_tx_done`.
  - Then, if count == `PKT_BYTES`, update `last`, clear `o_grant` and go to `IDLE`; otherwise go to `LOAD`.
- A non-granted source is never popped. Its valid is ignored until the next arbitration.
- Count register width is 8 bits; it never exceeds `PKT_BYTES`.
- The requester must keep data stable from valid-high until its ready pulse.
- Reset, including mid-burst:
  - State → `IDLE`; `o_tx_dv`, `o_col_ready`, `o_row_ready`, `o_grant`, `o_busy` → 0; `o_tx_byte` → 0; count → 0; `last` → row.
  - A byte already started in `uart_tx` is not tracked. Any `i_tx_done` arriving in `IDLE` is ignored.

## Timing
- Arbitration: valid seen in `IDLE` at cycle N → `o_grant`/`o_busy` high at N+1 → first `o_tx_dv` (header or payload) at N+2.
- Payload pop/transmit:
  - `o_tx_dv` and the ready pulse are both registered outputs and assert together, for exactly one cycle.
  - A pop happens one cycle after the `LOAD` decision.
- Back-to-back bytes: `i_tx_done` at cycle M → `LOAD` at M+1 → next `o_tx_dv` at M+2.
- Burst end: after the final `i_tx_done`, return to `IDLE` the next cycle; a new grant is possible one cycle later.
- Simultaneous requests: at most one grant per `IDLE` visit; alternation is strict under sustained contention.
- `i_tx_done` outside `WAIT_DONE` has no effect.

## Structure
- Shared package `sa_pkg`:
  - state enum `tx_sched_state_t`;
  - constants `GNT_COL=2'b01`, `GNT_ROW=2'b10`;
  - default header bytes.
- Single module with no sub-module. The round-robin picker is small enough to stay inline.
- Instantiated in the top level between the output-FIFO design and one `uart_tx` with `CLKS_PER_BIT=50`.

## Test plan
- **Single column burst**, `PKT_BYTES`=4, `HDR_EN`=1, column FIFO holds 11,22,33,44 → TX sequence C0,11,22,33,44; exactly 4 `o_col_ready` pulses; `o_grant` 01 → 00.
- **Contention**, `PKT_BYTES`=2, both FIFOs hold 4 bytes (col 01..04, row F1..F4) → C0,01,02,A0,F1,F2,C0,03,04,A0,F3,F4.
- **Short burst**: row FIFO holds 1 byte (5A) → A0,5A, then `IDLE`; no pop while row valid is low; a column request arriving later is granted next.
- **`HDR_EN`=0, single byte 7E** → `o_tx_dv` two cycles after valid; exactly one TX byte (7E), with no header.
- **Mid-burst reset**: `i_rst` asserted for 1 cycle during `WAIT_DONE` of byte 2 → all outputs 0 next cycle; a stray `i_tx_done` is ignored; a subsequent burst restarts with a header, and column wins the tie.
- **Stable hold**: a slow `i_tx_done` (5000-cycle delay) → `o_tx_byte` stays constant and there is no extra `o_tx_dv` or ready pulse during the wait.
